mem_access_ctrl: RTL and testbench

//  Initiator side of the shared single-port inst/data memory. Arbitrates instruction fetch and

---
 rtl/mem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator for the shared single-port inst/data memory: fetch/load-store arbitration, lane extraction and
// read-modify-write sub-word stores. Optional macro MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses.
module mem_access_ctrl #(
    parameter int WORD_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_wen,
    input  logic [31:0] mem_dout
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic                    if_valid_r;
    logic [31:0]             if_rdata_r;
    logic                    ls_done_r;
    logic [31:0]             ls_rdata_r;
    logic                    ls_err_r;
    logic [31:0]             merge_r;
    logic [WORD_IDX_W-1:0]   rmw_idx_r;

    logic                    idle_s;
    logic                    rmw_s;
    logic                    if_gnt_s;
    logic                    ls_gnt_s;
    logic                    is_word_s;
    logic                    misalign_s;
    logic                    st_word_s;
    logic                    st_sub_s;
    logic [WORD_IDX_W-1:0]   if_idx_s;
    logic [WORD_IDX_W-1:0]   ls_idx_s;
    logic [WORD_IDX_W-1:0]   mem_idx_s;
    logic [31:0]             mem_din_s;
    logic                    mem_wen_s;
    logic                    unused_s;

    // Selects the addressed lane of a read word and sign/zero-extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replaces the addressed byte/halfword of the old word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   r[7:0]   = wdata[7:0];
                    2'b01:   r[15:8]  = wdata[7:0];
                    2'b10:   r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign idle_s    = (state_r == ST_IDLE);
    assign rmw_s     = (state_r == ST_RMW_WR);
    assign ls_gnt_s  = idle_s & ls_req;
    assign if_gnt_s  = idle_s & if_req & ~ls_req;
    assign is_word_s = ls_size[1];
    assign if_idx_s  = if_addr[WORD_IDX_W+1:2];
    assign ls_idx_s  = ls_addr[WORD_IDX_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = ((ls_size == 2'b01) & ls_addr[0]) | (is_word_s & (ls_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    assign st_word_s = ls_gnt_s & ls_we & is_word_s & ~misalign_s;
    assign st_sub_s  = ls_gnt_s & ls_we & ~is_word_s & ~misalign_s;
    assign unused_s  = ^{if_addr[31:WORD_IDX_W+2], if_addr[1:0], ls_addr[31:WORD_IDX_W+2]};

    // Next state and memory pin drive; the RMW write phase owns the memory exclusively.
    always_comb begin
        state_nx_s = state_r;
        mem_wen_s  = 1'b0;
        mem_din_s  = 32'h00000000;
        mem_idx_s  = ls_req ? ls_idx_s : if_idx_s;
        case (state_r)
            ST_IDLE: begin
                if (st_word_s) begin
                    mem_wen_s  = 1'b1;
                    mem_din_s  = ls_wdata;
                    state_nx_s = ST_IDLE;
                end else if (st_sub_s) begin
                    state_nx_s = ST_RMW_WR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RMW_WR: begin
                mem_idx_s  = rmw_idx_r;
                mem_wen_s  = 1'b1;
                mem_din_s  = merge_r;
                state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Response registers: fetch and load/store completions, one cycle after grant or RMW write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_r <= 1'b0;
            if_rdata_r <= 32'h00000000;
            ls_done_r  <= 1'b0;
            ls_rdata_r <= 32'h00000000;
            ls_err_r   <= 1'b0;
        end else begin
            if_valid_r <= if_gnt_s;
            if (if_gnt_s) begin
                if_rdata_r <= mem_dout;
            end
            ls_done_r <= (ls_gnt_s & ~st_sub_s) | rmw_s;
            ls_err_r  <= ls_gnt_s & misalign_s;
            if (ls_gnt_s) begin
                ls_rdata_r <= (ls_we | misalign_s) ? 32'h00000000
                              : load_extract(mem_dout, ls_size, ls_unsigned, ls_addr[1:0]);
            end else if (rmw_s) begin
                ls_rdata_r <= 32'h00000000;
            end
        end
    end

    // Read phase of a sub-word store: capture the merged word and its index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            merge_r   <= 32'h00000000;
            rmw_idx_r <= '0;
        end else if (st_sub_s) begin
            merge_r   <= store_merge(mem_dout, ls_wdata, ls_size, ls_addr[1:0]);
            rmw_idx_r <= ls_idx_s;
        end
    end

    assign if_gnt   = if_gnt_s;
    assign ls_gnt   = ls_gnt_s;
    assign if_valid = if_valid_r;
    assign if_rdata = if_rdata_r;
    assign ls_done  = ls_done_r;
    assign ls_rdata = ls_rdata_r;
    assign ls_err   = ls_err_r;
    assign mem_addr = {{(32-WORD_IDX_W){1'b0}}, mem_idx_s};
    assign mem_din  = mem_din_s;
    assign mem_wen  = mem_wen_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized traffic
// against a word-array reference model of the memory.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_unsigned, ls_gnt, ls_done, ls_err;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_wen;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WORD_IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout)
    );

    // Single-port memory: combinational read, write on posedge; bench preload shares the port.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[4:0]] <= mem_din;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end
    assign mem_dout = mem[mem_addr[4:0]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx[4:0]; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int n;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr; #1;
        n = 0;
        while (!if_gnt && n < 8) begin @(negedge clk); #1; n++; end
        check_eq("if_gnt", if_gnt, 32'd1);
        @(negedge clk);
        if_req = 1'b0; #1;
        check_eq("if_valid", if_valid, 32'd1);
        check_eq("if_rdata", if_rdata, ref_mem[addr[6:2]]);
        check_eq("ls_done_idle", ls_done, 32'd0);
    endtask

    task automatic do_ls(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int idx, sh, n, sz;
        logic [31:0] old, v, mask, nw;
        logic err;
        idx = int'(addr[6:2]);
        sz  = (size == 2'd3) ? 2 : int'(size);
        sh  = (sz == 0) ? 8 * int'(addr[1:0]) : (sz == 1) ? 16 * int'(addr[1]) : 0;
        err = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        err = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`endif
        old = ref_mem[idx];
        v   = old >> sh;
        if (sz == 0) begin
            v = v & 32'h000000FF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
            mask = 32'h000000FF << sh;
        end else if (sz == 1) begin
            v = v & 32'h0000FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
            mask = 32'h0000FFFF << sh;
        end else begin
            mask = 32'hFFFFFFFF;
        end
        nw = (old & ~mask) | ((wdata << sh) & mask);

        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns; ls_addr = addr; ls_wdata = wdata; #1;
        n = 0;
        while (!ls_gnt && n < 8) begin @(negedge clk); #1; n++; end
        check_eq("ls_gnt", ls_gnt, 32'd1);
        check_eq("if_gnt_blocked", if_gnt, 32'd0);
        if (!ls_gnt) begin ls_req = 1'b0; return; end
        if (we && !err && sz == 2) begin
            check_eq("wr_wen", mem_wen, 32'd1);
            check_eq("wr_din", mem_din, wdata);
            check_eq("wr_addr", mem_addr, idx);
        end else begin
            check_eq("rd_wen", mem_wen, 32'd0);
        end
        @(negedge clk);
        ls_req = 1'b0; #1;
        if (we && !err && sz != 2) begin
            check_eq("rmw_done_early", ls_done, 32'd0);
            check_eq("rmw_wen", mem_wen, 32'd1);
            check_eq("rmw_din", mem_din, nw);
            check_eq("rmw_addr", mem_addr, idx);
            check_eq("rmw_if_gnt", if_gnt, 32'd0);
            @(negedge clk); #1;
        end
        check_eq("ls_done", ls_done, 32'd1);
        check_eq("ls_err", ls_err, err);
        check_eq("ls_rdata", ls_rdata, (we || err) ? 32'h0 : v);
        check_eq("if_valid_excl", if_valid, 32'd0);
        if (we && !err) ref_mem[idx] = nw;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = 5'd0; pre_data = 32'h0;
        for (int i = 0; i < 32; i++) preload(i, $urandom());
        #1;
        check_eq("rst_if_valid", if_valid, 32'd0);
        check_eq("rst_ls_done", ls_done, 32'd0);
        check_eq("rst_ls_err", ls_err, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_ls_rdata", ls_rdata, 32'h0);
        check_eq("rst_mem_wen", mem_wen, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Loads: word, byte, signed/unsigned halfword
        preload(3, 32'h11223344);
        do_ls(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
        do_ls(1'b0, 2'b00, 1'b0, 32'h0000000E, 32'h0);
        preload(3, 32'h80FF0000);
        do_ls(1'b0, 2'b01, 1'b0, 32'h0000000E, 32'h0);
        do_ls(1'b0, 2'b01, 1'b1, 32'h0000000E, 32'h0);

        // Byte store via RMW with a fetch waiting behind it
        preload(2, 32'hAABBCCDD);
        if_req = 1'b1; if_addr = 32'h0000000C;
        do_ls(1'b1, 2'b00, 1'b0, 32'h00000009, 32'h00000055);
        check_eq("sb_result", ref_mem[2], 32'hAABB55DD);
        check_eq("if_gnt_after_rmw", if_gnt, 32'd1);
        @(negedge clk); if_req = 1'b0; #1;
        check_eq("if_valid_after_rmw", if_valid, 32'd1);
        check_eq("if_rdata_after_rmw", if_rdata, ref_mem[3]);

        // Simultaneous requests, then three back-to-back fetches
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h00000020;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h00000010; #1;
        check_eq("prio_ls_gnt", ls_gnt, 32'd1);
        check_eq("prio_if_gnt", if_gnt, 32'd0);
        @(negedge clk); ls_req = 1'b0; if_addr = 32'h0; #1;
        check_eq("prio_ls_done", ls_done, 32'd1);
        check_eq("prio_ls_rdata", ls_rdata, ref_mem[4]);
        check_eq("b2b_gnt0", if_gnt, 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) if_addr = 32'(4 * i);
            else if_req = 1'b0;
            #1;
            check_eq("b2b_valid", if_valid, 32'd1);
            check_eq("b2b_rdata", if_rdata, ref_mem[i-1]);
            check_eq("b2b_no_ls_done", ls_done, 32'd0);
            if (i < 3) check_eq("b2b_gnt", if_gnt, 32'd1);
        end

        // Reset during the RMW write phase of a halfword store
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h00000012; ls_wdata = 32'h0000BEEF; #1;
        check_eq("rstrmw_gnt", ls_gnt, 32'd1);
        @(negedge clk); ls_req = 1'b0; rst = 1'b1; #1;
        check_eq("rstrmw_wen", mem_wen, 32'd0);
        check_eq("rstrmw_done", ls_done, 32'd0);
        check_eq("rstrmw_if_rdata", if_rdata, 32'h0);
        check_eq("rstrmw_ls_rdata", ls_rdata, 32'h0);
        check_eq("rstrmw_if_valid", if_valid, 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b0; #1;
        check_eq("rstrmw_mem", mem[4], ref_mem[4]);
        check_eq("rstrmw_done_after", ls_done, 32'd0);

        // Misaligned word load
        do_ls(1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0);

        // Randomized traffic with address wrap
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_fetch($urandom() & 32'hFFFFFFFC);
            end else begin
                do_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom(), $urandom());
            end
        end

        for (int i = 0; i < 32; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
